// File: rtl/ifetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues in-order memory requests and
// buffers PC-tagged instructions for decode; redirects flush and restart fetch.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     mem_req_valid,
    output logic [31:0]              mem_req_addr,
    input  logic                     mem_req_ready,
    input  logic                     mem_resp_valid,
    input  logic [31:0]              mem_resp_data,
    output logic                     out_valid,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      fetch_pc;
    logic [31:0]      slot_pc   [DEPTH];
    logic [31:0]      slot_data [DEPTH];
    logic [DEPTH-1:0] slot_filled;
    logic [PTR_W-1:0] alloc_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] alloc_count;
    logic [CNT_W-1:0] discard;
    logic             started;

    logic             accept;
    logic             pop;
    logic [CNT_W-1:0] filled_cnt;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] redirect_discard;
    logic [CNT_W:0]   budget;
    logic [1:0]       unused_pc_bits;

    assign unused_pc_bits = redirect_pc[1:0];

    // Issue is held off for one cycle after reset and whenever the slots plus
    // stale in-flight responses already cover the whole queue.
    assign budget        = {1'b0, alloc_count} + {1'b0, discard};
    assign mem_req_valid = started && !reset && !redirect_valid && (budget < (CNT_W+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc;
    assign accept        = mem_req_valid && mem_req_ready;

    assign out_valid = slot_filled[rd_ptr] && !redirect_valid && !reset;
    assign out_inst  = slot_data[rd_ptr];
    assign out_pc    = slot_pc[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign occupancy = alloc_count;

    // Allocated-but-unfilled slots are exactly the requests still in flight.
    always_comb begin
        filled_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            filled_cnt = filled_cnt + CNT_W'(slot_filled[i]);
        end
    end

    assign outstanding      = alloc_count - filled_cnt;
    assign redirect_discard = discard + outstanding - CNT_W'(mem_resp_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            slot_filled <= '0;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            alloc_count <= '0;
            discard     <= '0;
            started     <= 1'b0;
        end else begin
            started <= 1'b1;
            if (redirect_valid) begin
                fetch_pc    <= {redirect_pc[31:2], 2'b00};
                slot_filled <= '0;
                alloc_ptr   <= '0;
                fill_ptr    <= '0;
                rd_ptr      <= '0;
                alloc_count <= '0;
                discard     <= redirect_discard;
            end else begin
                if (accept) begin
                    slot_pc[alloc_ptr] <= fetch_pc;
                    alloc_ptr          <= alloc_ptr + PTR_W'(1);
                    fetch_pc           <= fetch_pc + 32'd4;
                end
                if (pop) begin
                    slot_filled[rd_ptr] <= 1'b0;
                    rd_ptr              <= rd_ptr + PTR_W'(1);
                end
                // Responses owed to flushed requests are swallowed before any slot fills.
                if (mem_resp_valid) begin
                    if (discard != '0) begin
                        discard <= discard - CNT_W'(1);
                    end else begin
                        slot_data[fill_ptr]   <= mem_resp_data;
                        slot_filled[fill_ptr] <= 1'b1;
                        fill_ptr              <= fill_ptr + PTR_W'(1);
                    end
                end
                case ({accept, pop})
                    2'b10:   alloc_count <= alloc_count + CNT_W'(1);
                    2'b01:   alloc_count <= alloc_count - CNT_W'(1);
                    default: alloc_count <= alloc_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: in-order latency memory model plus a stream-level
// reference (expected PC sequence, slot counts, stale in-flight requests).
module tb_ifetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b1;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready = 1'b1;
    logic [2:0]  occupancy;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t       memq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          last_due = 0;
    int          mem_lat = 1;
    int          m_occ = 0;
    int          m_filled = 0;
    bit          m_started = 0;
    logic [31:0] m_fetch = RESET_PC;
    logic [31:0] m_exp_pc = RESET_PC;

    function automatic int stale_cnt();
        int n = 0;
        foreach (memq[i]) if (memq[i].epoch != epoch) n++;
        return n;
    endfunction

    function automatic bit resp_due();
        return memq.size() > 0 && memq[0].due <= cyc;
    endfunction

    // One clock of memory model + reference stream; called at posedge+1.
    task automatic tick();
        bit    rsp, acc, pop, exp_rv, exp_ov;
        int    stale;
        mreq_t h;
        rsp = !reset && resp_due();
        mem_resp_valid = rsp;
        mem_resp_data  = rsp ? (memq[0].addr ^ KEY) : $urandom();
        @(negedge clk);
        stale  = stale_cnt();
        exp_rv = !reset && !redirect_valid && m_started && (m_occ + stale < DEPTH);
        exp_ov = !reset && !redirect_valid && (m_filled > 0);
        checks++;
        if (mem_req_valid !== exp_rv) begin
            errors++; $display("FAIL req_valid cyc=%0d: got %b want %b", cyc, mem_req_valid, exp_rv);
        end
        if (exp_rv) begin
            checks++;
            if (mem_req_addr !== m_fetch) begin
                errors++; $display("FAIL req_addr cyc=%0d: got %h want %h", cyc, mem_req_addr, m_fetch);
            end
        end
        checks++;
        if (occupancy !== 3'(m_occ)) begin
            errors++; $display("FAIL occupancy cyc=%0d: got %0d want %0d", cyc, occupancy, m_occ);
        end
        checks++;
        if (out_valid !== exp_ov) begin
            errors++; $display("FAIL out_valid cyc=%0d: got %b want %b", cyc, out_valid, exp_ov);
        end
        if (exp_ov && out_valid === 1'b1) begin
            checks++;
            if (out_pc !== m_exp_pc || out_inst !== (m_exp_pc ^ KEY)) begin
                errors++;
                $display("FAIL out_data cyc=%0d: got pc=%h inst=%h want pc=%h inst=%h",
                         cyc, out_pc, out_inst, m_exp_pc, m_exp_pc ^ KEY);
            end
        end
        acc = (mem_req_valid === 1'b1) && mem_req_ready;
        pop = (out_valid === 1'b1) && out_ready;
        @(posedge clk);
        if (reset) begin
            memq.delete();
            m_fetch = RESET_PC; m_exp_pc = RESET_PC;
            m_occ = 0; m_filled = 0; m_started = 0; last_due = 0;
        end else begin
            if (rsp) begin
                h = memq.pop_front();
                if (!redirect_valid && h.epoch == epoch) m_filled++;
            end
            if (redirect_valid) begin
                epoch++;
                m_occ = 0; m_filled = 0;
                m_fetch  = {redirect_pc[31:2], 2'b00};
                m_exp_pc = m_fetch;
            end else begin
                if (acc) begin
                    h.addr  = m_fetch;
                    h.due   = (cyc + mem_lat > last_due + 1) ? cyc + mem_lat : last_due + 1;
                    h.epoch = epoch;
                    last_due = h.due;
                    memq.push_back(h);
                    m_fetch = m_fetch + 32'd4;
                    m_occ++;
                end
                if (pop) begin
                    m_filled--; m_occ--;
                    m_exp_pc = m_exp_pc + 32'd4;
                end
            end
            m_started = 1;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_req_ready = 1'b1; out_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || out_valid !== 1'b0 || occupancy !== 3'd0) begin
            errors++; $display("FAIL reset_state: got rv=%b ov=%b occ=%0d want 0 0 0", mem_req_valid, out_valid, occupancy);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got %b want 0", mem_req_valid);
        end
        tick();
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin
            errors++; $display("FAIL first_req: got v=%b addr=%h want 1 %h", mem_req_valid, mem_req_addr, RESET_PC);
        end
        tick();
    endtask

    task automatic test_stream();
        mem_lat = 1; mem_req_ready = 1'b1; out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 24; k++) begin
            #1;
            checks++;
            if (k < 3) begin
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL stream_early k=%0d: got %b want 0", k, out_valid);
                end
            end else if (out_valid !== 1'b1 || out_pc !== 32'(4 * (k - 3)) || out_inst !== (32'(4 * (k - 3)) ^ KEY)) begin
                errors++; $display("FAIL stream k=%0d: got v=%b pc=%h inst=%h want pc=%h", k, out_valid, out_pc, out_inst, 32'(4 * (k - 3)));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held_inst;
        bit          seen = 0;
        mem_lat = 1; mem_req_ready = 1'b1; out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            #1;
            if (out_valid === 1'b1) begin
                if (seen) begin
                    checks++;
                    if (out_pc !== 32'h0 || out_inst !== held_inst) begin
                        errors++; $display("FAIL hold k=%0d: got pc=%h inst=%h want 0 %h", k, out_pc, out_inst, held_inst);
                    end
                end
                seen = 1; held_inst = out_inst;
            end
            tick();
        end
        #1;
        checks++;
        if (occupancy !== 3'd4 || mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL full: got occ=%0d rv=%b want 4 0", occupancy, mem_req_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin
                errors++; $display("FAIL drain i=%0d: got v=%b pc=%h want 1 %h", i, out_valid, out_pc, 32'(4 * i));
            end
            tick();
        end
    endtask

    task automatic test_redirect_drop();
        int i;
        mem_lat = 3; mem_req_ready = 1'b1; out_ready = 1'b1;
        do_reset();
        for (i = 0; i < 30 && memq.size() != 3; i++) tick();
        checks++;
        if (memq.size() != 3) begin
            errors++; $display("FAIL redir_setup: got %0d outstanding want 3", memq.size());
        end
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
            errors++; $display("FAIL redir_req: got v=%b addr=%h want 1 00000100", mem_req_valid, mem_req_addr);
        end
        for (i = 0; i < 20 && out_valid !== 1'b1; i++) begin tick(); #1; end
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== (32'h100 ^ KEY)) begin
            errors++; $display("FAIL redir_first: got v=%b pc=%h inst=%h want pc=00000100", out_valid, out_pc, out_inst);
        end
        tick();
    endtask

    task automatic test_redirect_with_resp();
        int i;
        mem_lat = 2; mem_req_ready = 1'b1; out_ready = 1'b1;
        do_reset();
        for (i = 0; i < 30 && !(memq.size() == 2 && resp_due()); i++) tick();
        checks++;
        if (!(memq.size() == 2 && resp_due())) begin
            errors++; $display("FAIL rr_setup: got %0d outstanding want 2 with response due", memq.size());
        end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || stale_cnt() != 1) begin
            errors++; $display("FAIL rr_drop: got ov=%b stale=%0d want 0 1", out_valid, stale_cnt());
        end
        for (i = 0; i < 20 && out_valid !== 1'b1; i++) begin tick(); #1; end
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
            errors++; $display("FAIL rr_first: got v=%b pc=%h want 1 00000200", out_valid, out_pc);
        end
        tick();
    endtask

    task automatic test_req_stall();
        mem_lat = 1; mem_req_ready = 1'b0; out_ready = 1'b1;
        do_reset();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h20) begin
                errors++; $display("FAIL stall k=%0d: got v=%b addr=%h want 1 00000020", k, mem_req_valid, mem_req_addr);
            end
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (mem_req_addr !== 32'h24) begin
            errors++; $display("FAIL stall_next: got %h want 00000024", mem_req_addr);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        int i;
        mem_lat = 1; mem_req_ready = 1'b1; out_ready = 1'b0;
        do_reset();
        for (i = 0; i < 20 && !(m_filled == 2 && memq.size() == 1); i++) tick();
        checks++;
        if (!(m_filled == 2 && memq.size() == 1)) begin
            errors++; $display("FAIL mid_setup: got filled=%0d outstanding=%0d want 2 1", m_filled, memq.size());
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 3'd0 || mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got ov=%b occ=%0d rv=%b want 0 0 0", out_valid, occupancy, mem_req_valid);
        end
        tick();
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin
            errors++; $display("FAIL mid_first_req: got v=%b addr=%h want 1 %h", mem_req_valid, mem_req_addr, RESET_PC);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            mem_lat        = int'($urandom_range(1, 4));
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = $urandom();
            reset          = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_with_resp();
        test_req_stall();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
